// File: rtl/conv_mac_tree.sv
// conv_mac_tree
//   Fully pipelined signed multiply-add tree for one convolution window.
//   It multiplies NUM_TAPS pixels by NUM_TAPS kernel coefficients and sums
//   the products in a registered binary adder tree. The final stage then
//   adds an optional bias, applies a rounding right shift and saturates the
//   result to OUT_W bits. All stages advance together under one enable:
//   adv = !out_valid || out_ready.
//
//   Optional feature macro: CONV_BIAS_EN
//     When it is defined, a per-window signed bias port exists. The bias
//     travels down the pipeline with its window and is added before
//     rounding and saturation.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   window data valid
//   in_ready   a window is accepted this cycle (equals adv)
//   in_data    NUM_TAPS signed pixels, tap i at [DATA_W*(i+1)-1 : DATA_W*i]
//   kernel     NUM_TAPS signed coefficients, packed the same way
//   bias       signed bias, OUT_W+OUT_SHIFT bits (CONV_BIAS_EN only)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   signed result, forced to 0 while out_valid is low
//   out_sat    result was clipped, qualified by out_valid

module conv_mac_tree #(
  parameter int NUM_TAPS  = 9,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_TAPS*DATA_W-1:0]     in_data,
  input  logic [NUM_TAPS*COEF_W-1:0]     kernel,
`ifdef CONV_BIAS_EN
  input  logic signed [OUT_W+OUT_SHIFT-1:0] bias,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_sat
);

  localparam int LEVELS = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 0;
  localparam int LEAVES = 1 << LEVELS;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + LEVELS;
`ifdef CONV_BIAS_EN
  localparam int BIAS_W = OUT_W + OUT_SHIFT;
  localparam int ACC_W  = ((SUM_W > BIAS_W) ? SUM_W : BIAS_W) + 1;
`else
  localparam int ACC_W  = SUM_W;
`endif
  // One spare bit lets the rounding constant be added without overflow,
  // even when OUT_SHIFT is wide compared with the sum.
  localparam int RND_W  = ((ACC_W > OUT_SHIFT + 1) ? ACC_W : OUT_SHIFT + 1) + 1;
  // The clip comparison is done wide enough to hold the result and both
  // OUT_W limits, so narrow sums never wrap against the constants.
  localparam int CMP_W  = ((RND_W > OUT_W) ? RND_W : OUT_W) + 1;

  localparam logic signed [RND_W-1:0] RND_HALF =
    (OUT_SHIFT > 0) ? (RND_W'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
  localparam logic signed [CMP_W-1:0] MAX_C = (CMP_W'(1) <<< (OUT_W - 1)) - CMP_W'(1);
  localparam logic signed [CMP_W-1:0] MIN_C = -(CMP_W'(1) <<< (OUT_W - 1));

  logic                    adv;
  logic [LEVELS:0]         vld;
  // tree[0] holds the products. tree[l] holds the sums of adder level l.
  // Every node is stored at SUM_W. Upper bits that never toggle are
  // trimmed by synthesis.
  logic signed [SUM_W-1:0] tree [0:LEVELS][0:LEAVES-1];
  logic signed [SUM_W-1:0] prod [0:LEAVES-1];
`ifdef CONV_BIAS_EN
  logic signed [BIAS_W-1:0] bias_pipe [0:LEVELS];
`endif
  logic signed [RND_W-1:0] acc;
  logic signed [RND_W-1:0] rnd;
  logic signed [RND_W-1:0] shifted;
  logic signed [CMP_W-1:0] wide;
  logic signed [OUT_W-1:0] nxt_data;
  logic                    nxt_sat;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Products are padded with zero leaves up to a power of two. An odd node
  // is then added to zero, which passes it through a level unchanged.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      prod[i] = '0;
    end
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod[i] = SUM_W'(PROD_W'($signed(in_data[i*DATA_W +: DATA_W])) *
                       PROD_W'($signed(kernel[i*COEF_W +: COEF_W])));
    end
  end

  // Output stage: bias, round half toward +inf with an arithmetic shift,
  // then clip to the signed OUT_W range.
  always_comb begin
`ifdef CONV_BIAS_EN
    acc = RND_W'(tree[LEVELS][0]) + RND_W'(bias_pipe[LEVELS]);
`else
    acc = RND_W'(tree[LEVELS][0]);
`endif
    rnd      = acc + RND_HALF;
    shifted  = rnd >>> OUT_SHIFT;
    wide     = CMP_W'(shifted);
    nxt_sat  = 1'b0;
    nxt_data = OUT_W'(wide);
    if (wide > MAX_C) begin
      nxt_data = OUT_W'(MAX_C);
      nxt_sat  = 1'b1;
    end else if (wide < MIN_C) begin
      nxt_data = OUT_W'(MIN_C);
      nxt_sat  = 1'b1;
    end
  end

  // The whole pipeline moves in lockstep under adv. A stall freezes every
  // stage, including the output registers, so held results stay stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      for (int l = 0; l <= LEVELS; l++) begin
        for (int j = 0; j < LEAVES; j++) begin
          tree[l][j] <= '0;
        end
`ifdef CONV_BIAS_EN
        bias_pipe[l] <= '0;
`endif
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      vld[0] <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < LEAVES; i++) begin
          tree[0][i] <= prod[i];
        end
`ifdef CONV_BIAS_EN
        bias_pipe[0] <= bias;
`endif
      end
      for (int l = 1; l <= LEVELS; l++) begin
        vld[l] <= vld[l-1];
`ifdef CONV_BIAS_EN
        bias_pipe[l] <= bias_pipe[l-1];
`endif
        for (int j = 0; j < LEAVES; j++) begin
          if (j < (LEAVES >> l)) begin
            tree[l][j] <= tree[l-1][(2*j < LEAVES) ? 2*j : 0] +
                          tree[l-1][(2*j+1 < LEAVES) ? 2*j+1 : 0];
          end else begin
            tree[l][j] <= '0;
          end
        end
      end
      out_valid <= vld[LEVELS];
      out_data  <= vld[LEVELS] ? nxt_data : '0;
      out_sat   <= vld[LEVELS] && nxt_sat;
    end
  end

endmodule

// File: tb/tb_conv_mac_tree.sv
// tb_conv_mac_tree
//   Directed testbench for conv_mac_tree.
//   dut    : default parameters (NUM_TAPS=9, 8x8 bit, OUT_W=16, OUT_SHIFT=0)
//   dut_sh : the same block with OUT_SHIFT=4, driven by the same inputs
//   The bias checks are built only when CONV_BIAS_EN is defined.

module tb_conv_mac_tree;

  localparam int NT = 9;

  logic                clock = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                out_ready;
  logic [NT*8-1:0]     in_data;
  logic [NT*8-1:0]     kernel;
  logic                in_ready, out_valid, out_sat;
  logic signed [15:0]  out_data;
  logic                in_ready_sh, out_valid_sh, out_sat_sh;
  logic signed [15:0]  out_data_sh;
`ifdef CONV_BIAS_EN
  logic signed [15:0]  bias;
  logic signed [19:0]  bias_sh;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  conv_mac_tree dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .kernel    (kernel),
`ifdef CONV_BIAS_EN
    .bias      (bias),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  conv_mac_tree #(.OUT_SHIFT(4)) dut_sh (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_sh),
    .in_data   (in_data),
    .kernel    (kernel),
`ifdef CONV_BIAS_EN
    .bias      (bias_sh),
`endif
    .out_valid (out_valid_sh),
    .out_ready (out_ready),
    .out_data  (out_data_sh),
    .out_sat   (out_sat_sh)
  );

  function automatic logic [NT*8-1:0] all_taps(input logic [7:0] v);
    return {NT{v}};
  endfunction

  function automatic logic [NT*8-1:0] one_tap(input logic [7:0] v);
    logic [NT*8-1:0] r;
    r = '0;
    r[7:0] = v;
    return r;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Sends one window into an empty pipeline with out_ready high. It returns
  // the cycle count to the first out_valid (capped at 20), both results, and
  // out_valid one cycle after the result.
  task automatic send_and_wait(input logic [NT*8-1:0] din, input logic [NT*8-1:0] kern,
                               output int lat, output logic signed [15:0] d, output logic s,
                               output logic signed [15:0] d_sh, output logic s_sh,
                               output logic v_after);
    in_data  = din;
    kernel   = kern;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    d    = out_data;
    s    = out_sat;
    d_sh = out_data_sh;
    s_sh = out_sat_sh;
    step();
    v_after = out_valid;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    kernel    = '0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (out_data !== 16'sd0) begin bad++; $display("[TB] FAIL reset_data: got %0d want 0", out_data); end
    total++;
    if (out_sat !== 1'b0) begin bad++; $display("[TB] FAIL reset_sat: got %b want 0", out_sat); end
    reset = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_latency;
    int lat;
    logic signed [15:0] d, d_sh;
    logic s, s_sh, va;
    send_and_wait(all_taps(8'h01), all_taps(8'h01), lat, d, s, d_sh, s_sh, va);
    total++;
    if (lat !== 6) begin bad++; $display("[TB] FAIL latency: got %0d want 6", lat); end
    total++;
    if (d !== 16'sd9) begin bad++; $display("[TB] FAIL basic_sum: got %0d want 9", d); end
    total++;
    if (s !== 1'b0) begin bad++; $display("[TB] FAIL basic_sat: got %b want 0", s); end
    total++;
    if (va !== 1'b0) begin bad++; $display("[TB] FAIL single_pulse: got %b want 0", va); end
    total++;
    if (d_sh !== 16'sd1) begin bad++; $display("[TB] FAIL basic_sum_sh: got %0d want 1", d_sh); end
  endtask

  task automatic test_saturation;
    int lat;
    logic signed [15:0] d, d_sh;
    logic s, s_sh, va;
    send_and_wait(all_taps(8'h80), all_taps(8'h80), lat, d, s, d_sh, s_sh, va);
    total++;
    if (d !== 16'sd32767) begin bad++; $display("[TB] FAIL sat_pos_data: got %0d want 32767", d); end
    total++;
    if (s !== 1'b1) begin bad++; $display("[TB] FAIL sat_pos_flag: got %b want 1", s); end
    total++;
    if (d_sh !== 16'sd9216 || s_sh !== 1'b0) begin
      bad++; $display("[TB] FAIL sat_pos_sh: got %0d/%b want 9216/0", d_sh, s_sh);
    end
    send_and_wait(all_taps(8'h80), all_taps(8'h7F), lat, d, s, d_sh, s_sh, va);
    total++;
    if (d !== 16'sh8000) begin bad++; $display("[TB] FAIL sat_neg_data: got %0d want -32768", d); end
    total++;
    if (s !== 1'b1) begin bad++; $display("[TB] FAIL sat_neg_flag: got %b want 1", s); end
    total++;
    if (d_sh !== -16'sd9144 || s_sh !== 1'b0) begin
      bad++; $display("[TB] FAIL sat_neg_sh: got %0d/%b want -9144/0", d_sh, s_sh);
    end
  endtask

  task automatic test_rounding;
    logic [7:0]         rv   [4] = '{8'd24, 8'hE8, 8'd8, 8'd7};
    logic signed [15:0] rexp [4] = '{16'sd24, -16'sd24, 16'sd8, 16'sd7};
    logic signed [15:0] rsh  [4] = '{16'sd2, -16'sd1, 16'sd1, 16'sd0};
    int lat;
    logic signed [15:0] d, d_sh;
    logic s, s_sh, va;
    for (int k = 0; k < 4; k++) begin
      send_and_wait(one_tap(rv[k]), one_tap(8'h01), lat, d, s, d_sh, s_sh, va);
      total++;
      if (d_sh !== rsh[k]) begin
        bad++; $display("[TB] FAIL round_sh[%0d]: got %0d want %0d", k, d_sh, rsh[k]);
      end
      total++;
      if (d !== rexp[k]) begin
        bad++; $display("[TB] FAIL round_noshift[%0d]: got %0d want %0d", k, d, rexp[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got = 0;
    int stall_left = 5;
    int cyc = 0;
    logic stalled;
    out_ready = 1'b1;
    kernel = all_taps(8'h01);
    while (got < 10 && cyc < 80) begin
      stalled = 1'b0;
      if (got >= 1 && stall_left > 0) begin
        stalled = 1'b1;
        stall_left--;
      end
      out_ready = !stalled;
      #1;
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_stall_valid: got %b want 1 (cycle %0d)", out_valid, cyc); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_stall_in_ready: got %b want 0 (cycle %0d)", in_ready, cyc); end
      end else begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_in_ready: got %b want 1 (cycle %0d)", in_ready, cyc); end
      end
      if (out_valid === 1'b1) begin
        total++;
        if (out_data !== 16'(9 * (got + 1)) || out_sat !== 1'b0) begin
          bad++; $display("[TB] FAIL bp_order: got %0d/%b want %0d/0", out_data, out_sat, 9 * (got + 1));
        end
        if (out_ready) got++;
      end else begin
        total++;
        if (out_data !== 16'sd0) begin bad++; $display("[TB] FAIL bp_idle_data: got %0d want 0", out_data); end
      end
      in_valid = (sent < 10);
      in_data  = all_taps(8'(sent + 1));
      if (in_valid && in_ready) sent++;
      @(posedge clock);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got !== 10) begin bad++; $display("[TB] FAIL bp_count_out: got %0d want 10", got); end
    total++;
    if (sent !== 10) begin bad++; $display("[TB] FAIL bp_count_in: got %0d want 10", sent); end
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_reset_midstream;
    int vcount = 0;
    int lat;
    logic signed [15:0] d, d_sh;
    logic s, s_sh, va;
    out_ready = 1'b1;
    kernel = all_taps(8'h01);
    for (int v = 2; v <= 4; v++) begin
      in_data  = all_taps(8'(v));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_state: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    for (int k = 0; k < 10; k++) begin
      if (out_valid !== 1'b0) vcount++;
      step();
    end
    total++;
    if (vcount !== 0) begin bad++; $display("[TB] FAIL midrst_flushed: got %0d valid cycles want 0", vcount); end
    send_and_wait(all_taps(8'h05), all_taps(8'h01), lat, d, s, d_sh, s_sh, va);
    total++;
    if (lat !== 6) begin bad++; $display("[TB] FAIL midrst_latency: got %0d want 6", lat); end
    total++;
    if (d !== 16'sd45 || s !== 1'b0) begin bad++; $display("[TB] FAIL midrst_data: got %0d/%b want 45/0", d, s); end
  endtask

`ifdef CONV_BIAS_EN
  task automatic test_bias;
    int lat;
    logic signed [15:0] d, d_sh;
    logic s, s_sh, va;
    bias = -16'sd20;
    send_and_wait(all_taps(8'h01), all_taps(8'h01), lat, d, s, d_sh, s_sh, va);
    total++;
    if (d !== -16'sd11 || s !== 1'b0) begin bad++; $display("[TB] FAIL bias_neg: got %0d/%b want -11/0", d, s); end
    bias = 16'sd32760;
    send_and_wait(all_taps(8'h01), all_taps(8'h01), lat, d, s, d_sh, s_sh, va);
    total++;
    if (d !== 16'sd32767 || s !== 1'b1) begin bad++; $display("[TB] FAIL bias_sat: got %0d/%b want 32767/1", d, s); end
    bias = '0;
  endtask
`endif

  initial begin
`ifdef CONV_BIAS_EN
    bias    = '0;
    bias_sh = '0;
`endif
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    kernel    = '0;
    test_reset();
    test_latency();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_midstream();
`ifdef CONV_BIAS_EN
    test_bias();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
